// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_gen_pkg : shared VGA raster defaults and axis state encoding
// Revision 1.0
// ============================================================================
package vga_timing_gen_pkg;

  localparam int POS_W       = 10;
  localparam int RES_H       = 640;
  localparam int RES_V       = 480;
  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;

  typedef enum logic [1:0] {
    AX_ACT = 2'd0,
    AX_FP  = 2'd1,
    AX_SYN = 2'd2,
    AX_BP  = 2'd3
  } axis_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_axis.sv
`default_nettype none
// ============================================================================
// vga_axis_counter : one raster axis (active/front/sync/back) position counter
// Revision 1.0
// ============================================================================
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE   = RES_H,
  parameter int FRONT    = H_FRONT_DEF,
  parameter int SYNC     = H_SYNC_DEF,
  parameter int BACK     = H_BACK_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [POS_W-1:0] count,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam logic [POS_W-1:0] ACT_LAST = POS_W'(ACTIVE - 1);
  localparam logic [POS_W-1:0] FP_LAST  = POS_W'(ACTIVE + FRONT - 1);
  localparam logic [POS_W-1:0] SYN_LAST = POS_W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [POS_W-1:0] TOT_LAST = POS_W'(ACTIVE + FRONT + SYNC + BACK - 1);

  axis_state_e      state_q, state_d;
  logic [POS_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;

  // Reset parks at the last back-porch position so the first step wraps to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= AX_BP;
      count_q <= TOT_LAST;
      sync_q  <= ~SYNC_POL;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sync_d  = sync_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      case (state_q)
        AX_ACT:  if (count_q == ACT_LAST) state_d = AX_FP;
        AX_FP:   if (count_q == FP_LAST)  state_d = AX_SYN;
        AX_SYN:  if (count_q == SYN_LAST) state_d = AX_BP;
        AX_BP:   if (wrap)                state_d = AX_ACT;
        default:                          state_d = AX_BP;
      endcase
      sync_d = (state_d == AX_SYN) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign wrap   = (count_q == TOT_LAST);
  assign count  = count_q;
  assign sync   = sync_q;
  assign active = (state_q == AX_ACT);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : VGA sync/position generator with per-frame sprite start
// Revision 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = RES_H,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = RES_V,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] spr_y,
  output logic             pix_tick,
  output logic [POS_W-1:0] pixel_x,
  output logic [POS_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start,
  output logic             spr_start
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] H_ACT_LAST = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] H_SYN_PRE  = POS_W'(H_ACTIVE + H_FRONT - 1);
  localparam logic [POS_W-1:0] V_ACT_LAST = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0] V_ACT_N    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick_q, pix_tick_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;
  logic             spr_start_q, spr_start_d;
  logic [POS_W-1:0] spr_y_q, spr_y_d;
  logic [POS_W-1:0] h_count, v_count, spr_line;
  logic             h_active, h_wrap, v_active, v_wrap, v_step;

  assign v_step = pix_tick_q & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(SYNC_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .step(pix_tick_q),
    .count(h_count), .sync(hsync), .active(h_active), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(SYNC_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .step(v_step),
    .count(v_count), .sync(vsync), .active(v_active), .wrap(v_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q         <= '0;
      pix_tick_q    <= 1'b0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      spr_start_q   <= 1'b0;
      spr_y_q       <= V_ACT_N;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= pix_tick_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      spr_start_q   <= spr_start_d;
      spr_y_q       <= spr_y_d;
    end
  end

  // video_on is computed one step ahead so it lands on the same edge as the position.
  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_tick_d    = (div_q == DIV_LAST);
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    spr_start_d   = 1'b0;
    spr_y_d       = spr_y_q;
    spr_line      = (spr_y_q == '0) ? V_LAST : spr_y_q - 1'b1;
    if (pix_tick_q) begin
      video_on_d = (h_wrap | (h_active & (h_count != H_ACT_LAST))) &
                   (h_wrap ? (v_wrap | (v_active & (v_count != V_ACT_LAST))) : v_active);
      if (h_wrap && v_wrap) begin
        frame_start_d = 1'b1;
        spr_y_d       = spr_y;
      end
      if ((h_count == H_SYN_PRE) && (v_count == spr_line) && (spr_y_q < V_ACT_N)) begin
        spr_start_d = 1'b1;
      end
    end
  end

  assign pix_tick    = pix_tick_q;
  assign pixel_x     = h_count;
  assign pixel_y     = v_count;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign spr_start   = spr_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : directed checks of vga_timing_gen (default and small raster)
// Revision 1.0
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [9:0] spr_y_a, spr_y_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       tick_a, hs_a, vs_a, von_a, fs_a, ss_a;
  logic       tick_b, hs_b, vs_b, von_b, fs_b, ss_b;

  // Default 640x480 raster, CLK_DIV=4.
  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .spr_y(spr_y_a), .pix_tick(tick_a),
    .pixel_x(x_a), .pixel_y(y_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .frame_start(fs_a), .spr_start(ss_a)
  );

  // Small raster: H 16/4/6/6 (total 32), V 12/2/2/4 (total 20), CLK_DIV=1.
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .spr_y(spr_y_b), .pix_tick(tick_b),
    .pixel_x(x_b), .pixel_y(y_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .frame_start(fs_b), .spr_start(ss_b)
  );

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       tick, hs, vs, von, fs, ss;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int k, input int x, input int y,
                              input bit tick, input bit hs, input bit vs,
                              input bit von, input bit fs, input bit ss);
    vec_t v;
    v.k = k; v.x = 10'(x); v.y = 10'(y);
    v.tick = tick; v.hs = hs; v.vs = vs; v.von = von; v.fs = fs; v.ss = ss;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v,
                         input logic [9:0] x, input logic [9:0] y,
                         input logic tick, input logic hs, input logic vs,
                         input logic von, input logic fs, input logic ss);
    string p;
    p = $sformatf("%s k=%0d", tag, v.k);
    chk({p, " pixel_x"},     32'(x),    32'(v.x));
    chk({p, " pixel_y"},     32'(y),    32'(v.y));
    chk({p, " pix_tick"},    32'(tick), 32'(v.tick));
    chk({p, " hsync"},       32'(hs),   32'(v.hs));
    chk({p, " vsync"},       32'(vs),   32'(v.vs));
    chk({p, " video_on"},    32'(von),  32'(v.von));
    chk({p, " frame_start"}, 32'(fs),   32'(v.fs));
    chk({p, " spr_start"},   32'(ss),   32'(v.ss));
  endtask

  int idx;
  int f;
  int von_clks, hs_clks, vs_clks, ss_clks, fs_clks, tick_low;
  int ss_cnt[4]   = '{default: 0};
  int exp_line[4] = '{4, 8, -1, 19};

  initial begin
    // k = clocks after reset release, sampled on the falling edge.
    //           k     x    y  tk hs vs von fs ss
    va.push_back(mk(1,    799, 524, 0, 1, 1, 0, 0, 0));
    va.push_back(mk(3,    799, 524, 0, 1, 1, 0, 0, 0));
    va.push_back(mk(4,    799, 524, 1, 1, 1, 0, 0, 0));
    va.push_back(mk(5,      0,   0, 0, 1, 1, 1, 1, 0));
    va.push_back(mk(6,      0,   0, 0, 1, 1, 1, 0, 0));
    va.push_back(mk(8,      0,   0, 1, 1, 1, 1, 0, 0));
    va.push_back(mk(9,      1,   0, 0, 1, 1, 1, 0, 0));
    va.push_back(mk(2564, 639,   0, 1, 1, 1, 1, 0, 0));
    va.push_back(mk(2565, 640,   0, 0, 1, 1, 0, 0, 0));
    va.push_back(mk(2628, 655,   0, 1, 1, 1, 0, 0, 0));
    va.push_back(mk(2629, 656,   0, 0, 0, 1, 0, 0, 1));
    va.push_back(mk(2630, 656,   0, 0, 0, 1, 0, 0, 0));
    va.push_back(mk(3012, 751,   0, 1, 0, 1, 0, 0, 0));
    va.push_back(mk(3013, 752,   0, 0, 1, 1, 0, 0, 0));
    va.push_back(mk(3204, 799,   0, 1, 1, 1, 0, 0, 0));
    va.push_back(mk(3205,   0,   1, 0, 1, 1, 1, 0, 0));

    vb.push_back(mk(1,     31, 19, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(2,      0,  0, 1, 1, 1, 1, 1, 0));
    vb.push_back(mk(3,      1,  0, 1, 1, 1, 1, 0, 0));
    vb.push_back(mk(17,    15,  0, 1, 1, 1, 1, 0, 0));
    vb.push_back(mk(18,    16,  0, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(21,    19,  0, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(22,    20,  0, 1, 0, 1, 0, 0, 0));
    vb.push_back(mk(27,    25,  0, 1, 0, 1, 0, 0, 0));
    vb.push_back(mk(28,    26,  0, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(34,     0,  1, 1, 1, 1, 1, 0, 0));
    vb.push_back(mk(150,   20,  4, 1, 0, 1, 0, 0, 1));
    vb.push_back(mk(151,   21,  4, 1, 0, 1, 0, 0, 0));
    vb.push_back(mk(354,    0, 11, 1, 1, 1, 1, 0, 0));
    vb.push_back(mk(386,    0, 12, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(449,   31, 13, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(450,    0, 14, 1, 1, 0, 0, 0, 0));
    vb.push_back(mk(513,   31, 15, 1, 1, 0, 0, 0, 0));
    vb.push_back(mk(514,    0, 16, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(641,   31, 19, 1, 1, 1, 0, 0, 0));
    vb.push_back(mk(642,    0,  0, 1, 1, 1, 1, 1, 0));
    vb.push_back(mk(918,   20,  8, 1, 0, 1, 0, 0, 1));
    vb.push_back(mk(1282,   0,  0, 1, 1, 1, 1, 1, 0));
    vb.push_back(mk(2550,  20, 19, 1, 0, 1, 0, 0, 1));
    vb.push_back(mk(2562,   0,  0, 1, 1, 1, 1, 1, 0));

    rst_a = 1'b0; rst_b = 1'b0;
    spr_y_a = 10'd1; spr_y_b = 10'd5;
    repeat (3) @(negedge clk);
    chk_vec("a_reset", mk(0, 799, 524, 0, 1, 1, 0, 0, 0), x_a, y_a, tick_a, hs_a, vs_a, von_a, fs_a, ss_a);
    chk_vec("b_reset", mk(0, 31, 19, 0, 1, 1, 0, 0, 0), x_b, y_b, tick_b, hs_b, vs_b, von_b, fs_b, ss_b);

    // Default raster: first tick latency and one full line.
    rst_a = 1'b1;
    idx = 0; von_clks = 0; hs_clks = 0; ss_clks = 0;
    for (int k = 1; k <= 3205; k++) begin
      @(negedge clk);
      if (idx < va.size() && va[idx].k == k) begin
        chk_vec("a", va[idx], x_a, y_a, tick_a, hs_a, vs_a, von_a, fs_a, ss_a);
        idx++;
      end
      if (k >= 5 && k <= 3204) begin
        if (von_a) von_clks++;
        if (!hs_a) hs_clks++;
        if (ss_a) begin
          ss_clks++;
          chk("a spr_start pixel_x", 32'(x_a), 656);
          chk("a spr_start pixel_y", 32'(y_a), 0);
        end
      end
    end
    chk("a video_on clks in line 0", von_clks, 640 * 4);
    chk("a hsync low clks in line 0", hs_clks, 96 * 4);
    chk("a spr_start clks in line 0", ss_clks, 1);

    // Small raster: four frames with spr_y changes, then a mid-line reset.
    rst_b = 1'b1;
    idx = 0; von_clks = 0; hs_clks = 0; vs_clks = 0; fs_clks = 0; tick_low = 0;
    for (int k = 1; k <= 2796; k++) begin
      @(negedge clk);
      if (idx < vb.size() && vb[idx].k == k) begin
        chk_vec("b", vb[idx], x_b, y_b, tick_b, hs_b, vs_b, von_b, fs_b, ss_b);
        idx++;
      end
      if (k >= 2 && k <= 2561) begin
        f = (k - 2) / 640;
        if (von_b)  von_clks++;
        if (!hs_b)  hs_clks++;
        if (!vs_b)  vs_clks++;
        if (fs_b)   fs_clks++;
        if (!tick_b) tick_low++;
        if (ss_b) begin
          ss_cnt[f]++;
          chk($sformatf("b frame %0d spr_start pixel_x", f), 32'(x_b), 20);
          chk($sformatf("b frame %0d spr_start pixel_y", f), 32'(y_b), exp_line[f]);
        end
        if (k == 641 + 640 * f)
          chk($sformatf("b frame %0d spr_start count", f), ss_cnt[f], (exp_line[f] >= 0) ? 1 : 0);
      end
      if (k == 66)   spr_y_b = 10'd9;
      if (k == 700)  spr_y_b = 10'd12;
      if (k == 1300) spr_y_b = 10'd0;
    end
    chk("b video_on clks 4 frames", von_clks, 16 * 12 * 4);
    chk("b hsync low clks 4 frames", hs_clks, 6 * 20 * 4);
    chk("b vsync low clks 4 frames", vs_clks, 2 * 32 * 4);
    chk("b frame_start count", fs_clks, 4);
    chk("b pix_tick low clks", tick_low, 0);
    chk("b pre-reset pixel_x", 32'(x_b), 10);
    chk("b pre-reset pixel_y", 32'(y_b), 7);

    rst_b = 1'b0;
    @(negedge clk);
    chk_vec("b_midreset", mk(0, 31, 19, 0, 1, 1, 0, 0, 0), x_b, y_b, tick_b, hs_b, vs_b, von_b, fs_b, ss_b);
    rst_b = 1'b1;
    @(negedge clk);
    chk_vec("b_restart", mk(1, 31, 19, 1, 1, 1, 0, 0, 0), x_b, y_b, tick_b, hs_b, vs_b, von_b, fs_b, ss_b);
    @(negedge clk);
    chk_vec("b_restart", mk(2, 0, 0, 1, 1, 1, 1, 1, 0), x_b, y_b, tick_b, hs_b, vs_b, von_b, fs_b, ss_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
